// File: rtl/mux_pkg.sv
// Shared types and channel constants for the 2:1 stream merge.
// Round-robin arbitration is selected by defining MUX_RR_EN; otherwise channel 0 has fixed priority.
package mux_pkg;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic logic other_channel(input logic ch);
        return ~ch;
    endfunction

endpackage

// File: rtl/mux_2_1_arbiter_grant.sv
// Combinational grant logic for the 2:1 stream merge.
// A channel's grant never looks at its own valid, only at the competitor's valid and the pointer.
module mux_2_1_arbiter_grant
    import mux_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       pointer,
    input  logic       enable,
    input  logic       can_load,
    output logic [1:0] grant
);

    logic active;

    // A channel loses only when the other channel is also requesting and the pointer favours it.
    always_comb begin
        active   = enable & can_load;
        grant[0] = active & (~valid[1] | (pointer == CH0));
        grant[1] = active & (~valid[0] | (pointer == CH1));
    end

endmodule

// File: rtl/mux_2_1_stream_arbiter.sv
// Merges two valid/ready sources into one registered valid/ready sink, tagging each word with its source.
// Define MUX_RR_EN for round-robin arbitration; the default build uses fixed priority to channel 0.
module mux_2_1_stream_arbiter
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic [DATA_WIDTH-1:0] Data_0_In,
    input  logic                  Valid_0_In,
    output logic                  Ready_0_Out,
    input  logic [DATA_WIDTH-1:0] Data_1_In,
    input  logic                  Valid_1_In,
    output logic                  Ready_1_Out,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Select_Out,
    output logic                  Valid_Out,
    input  logic                  Ready_In
);

    out_state_t            state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  select_q;
    logic                  valid_q;
    logic                  pointer;
    logic                  can_load;
    logic [1:0]            grant;
    logic [1:0]            transfer;
    logic                  load;
    logic                  load_sel;

    assign can_load = ~valid_q | Ready_In;

    mux_2_1_arbiter_grant u_grant (
        .valid    ({Valid_1_In, Valid_0_In}),
        .pointer  (pointer),
        .enable   (Enable_In),
        .can_load (can_load),
        .grant    (grant)
    );

    // Ready is forced low during reset so no source sees a handshake that cannot land.
    always_comb begin
        Ready_0_Out = grant[0] & ~Reset_In;
        Ready_1_Out = grant[1] & ~Reset_In;
        transfer    = {Valid_1_In & Ready_1_Out, Valid_0_In & Ready_0_Out};
        load        = |transfer;
        load_sel    = transfer[1] ? CH1 : CH0;
    end

    // Output register FSM: a load always wins over a drain, so drain+load swaps words with no bubble.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state    <= OUT_EMPTY;
            data_q   <= '0;
            select_q <= CH0;
            valid_q  <= 1'b0;
            pointer  <= CH0;
        end else begin
            case (state)
                OUT_EMPTY: begin
                    if (load) begin
                        state    <= OUT_FULL;
                        data_q   <= load_sel ? Data_1_In : Data_0_In;
                        select_q <= load_sel;
                        valid_q  <= 1'b1;
                    end
                end
                OUT_FULL: begin
                    if (load) begin
                        data_q   <= load_sel ? Data_1_In : Data_0_In;
                        select_q <= load_sel;
                    end else if (Ready_In) begin
                        state   <= OUT_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= OUT_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase

            if (load) begin
`ifdef MUX_RR_EN
                pointer <= other_channel(load_sel);
`else
                pointer <= CH0;
`endif
            end
        end
    end

    assign Data_Out   = data_q;
    assign Select_Out = select_q;
    assign Valid_Out  = valid_q;

endmodule

// File: tb/tb_mux_2_1_stream_arbiter.sv
// Self-checking bench for mux_2_1_stream_arbiter: directed scenarios plus a randomized run against a reference model.
// Honours MUX_RR_EN the same way as the design to pick the expected arbitration policy.
module tb_mux_2_1_stream_arbiter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] data_0;
    logic       valid_0;
    logic       ready_0;
    logic [7:0] data_1;
    logic       valid_1;
    logic       ready_1;
    logic [7:0] data_out;
    logic       select_out;
    logic       valid_out;
    logic       ready_in;

    int errors;
    int checks;

    mux_2_1_stream_arbiter #(.DATA_WIDTH(8)) dut (
        .Clock_In    (clock),
        .Reset_In    (reset),
        .Enable_In   (enable),
        .Data_0_In   (data_0),
        .Valid_0_In  (valid_0),
        .Ready_0_Out (ready_0),
        .Data_1_In   (data_1),
        .Valid_1_In  (valid_1),
        .Ready_1_Out (ready_1),
        .Data_Out    (data_out),
        .Select_Out  (select_out),
        .Valid_Out   (valid_out),
        .Ready_In    (ready_in)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        enable   = 1'b1;
        valid_0  = 1'b0;
        valid_1  = 1'b0;
        data_0   = 8'h00;
        data_1   = 8'h00;
        ready_in = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++;
        if ({data_out, select_out, valid_out, ready_0, ready_1} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%h expected=000", {data_out, select_out, valid_out, ready_0, ready_1});
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_valid got=%b expected=0", valid_out);
        end
    endtask

    task automatic test_single();
        valid_0 = 1'b1;
        data_0  = 8'hA5;
        #1;
        checks++;
        if (ready_0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ready0 got=%b expected=1", ready_0);
        end
        tick();
        valid_0 = 1'b0;
        checks++;
        if ({data_out, select_out, valid_out} !== {8'hA5, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL single_word got=%h/%b/%b expected=a5/0/1", data_out, select_out, valid_out);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_sel;
`ifdef MUX_RR_EN
        exp_sel = 4'b1010;
`else
        exp_sel = 4'b0000;
`endif
        do_reset();
        valid_0 = 1'b1;
        data_0  = 8'h10;
        valid_1 = 1'b1;
        data_1  = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (select_out !== exp_sel[i] || data_out !== (exp_sel[i] ? 8'h20 : 8'h10) || valid_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL contention_%0d got=%b/%h expected=%b", i, select_out, data_out, exp_sel[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        valid_0 = 1'b1;
        data_0  = 8'h3C;
        tick();
        data_0   = 8'h11;
        data_1   = 8'h22;
        valid_1  = 1'b1;
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (data_out !== 8'h3C || valid_out !== 1'b1 || ready_0 !== 1'b0 || ready_1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_%0d got=%h/%b rdy=%b%b expected=3c/1 rdy=00", i, data_out, valid_out, ready_0, ready_1);
            end
            tick();
        end
        valid_0  = 1'b0;
        valid_1  = 1'b0;
        ready_in = 1'b1;
        tick();
        checks++;
        if (valid_out !== 1'b0 || data_out !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL drain got=%b/%h expected=0/3c", valid_out, data_out);
        end
    endtask

    task automatic test_enable();
        enable  = 1'b0;
        valid_1 = 1'b1;
        data_1  = 8'h77;
        #1;
        checks++;
        if (ready_1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disabled_ready1 got=%b expected=0", ready_1);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disabled_valid got=%b expected=0", valid_out);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (ready_1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL enabled_ready1 got=%b expected=1", ready_1);
        end
        tick();
        valid_1 = 1'b0;
        checks++;
        if ({data_out, select_out, valid_out} !== {8'h77, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL enabled_word got=%h/%b/%b expected=77/1/1", data_out, select_out, valid_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid_0 = 1'b1;
        data_0  = 8'h5A;
        tick();
        valid_0  = 1'b0;
        ready_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 8'h00 || select_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got=%b/%h/%b expected=0/00/0", valid_out, data_out, select_out);
        end
        @(negedge clock);
        reset    = 1'b0;
        ready_in = 1'b1;
        valid_0  = 1'b1;
        data_0   = 8'h01;
        valid_1  = 1'b1;
        data_1   = 8'h02;
        tick();
        checks++;
        if (select_out !== 1'b0 || data_out !== 8'h01) begin
            errors++;
            $display("[TB] FAIL pointer_after_reset got=%b/%h expected=0/01", select_out, data_out);
        end
        idle_inputs();
        tick();
    endtask

    // Reference: a one-deep output slot plus a priority channel; words are accepted by the arbitration rules.
    task automatic test_random();
        int   ptr;
        bit   mv;
        bit   ms;
        logic [7:0] md;
        bit   pend0;
        bit   pend1;
        bit   active;
        bit   er0;
        bit   er1;
        bit   t0;
        bit   t1;
        do_reset();
        ptr   = 0;
        mv    = 1'b0;
        ms    = 1'b0;
        md    = 8'h00;
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pend0) begin
                valid_0 = ($urandom_range(0, 2) != 0);
                data_0  = 8'($urandom);
            end
            if (!pend1) begin
                valid_1 = ($urandom_range(0, 2) != 0);
                data_1  = 8'($urandom);
            end
            enable   = ($urandom_range(0, 7) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            #1;
            active = enable && (!mv || ready_in);
            er0 = active && !(valid_1 && ptr == 1);
            er1 = active && !(valid_0 && ptr == 0);
            checks++;
            if (ready_0 !== er0 || ready_1 !== er1) begin
                errors++;
                $display("[TB] FAIL rand_ready cyc=%0d got=%b%b expected=%b%b", cyc, ready_0, ready_1, er0, er1);
            end
            t0 = valid_0 && er0;
            t1 = valid_1 && er1;
            @(posedge clock);
            if (t0 || t1) begin
                md = t1 ? data_1 : data_0;
                ms = t1;
                mv = 1'b1;
`ifdef MUX_RR_EN
                ptr = t1 ? 0 : 1;
`endif
            end else if (mv && ready_in) begin
                mv = 1'b0;
            end
            pend0 = valid_0 && !t0;
            pend1 = valid_1 && !t1;
            @(negedge clock);
            checks++;
            if (valid_out !== mv || (mv && (data_out !== md || select_out !== ms))) begin
                errors++;
                $display("[TB] FAIL rand_out cyc=%0d got=%b/%h/%b expected=%b/%h/%b", cyc, valid_out, data_out, select_out, mv, md, ms);
            end
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
